// File: rtl/sobel_stream_if.sv
// Pixel stream bundle for sobel_stream_filter.
//   in_pixel/in_valid/in_ready     : raster-order input stream (valid/ready)
//   out_pixel/out_valid/out_ready  : raster-order output stream (valid/ready)
//   out_last                       : marks the final output pixel of a frame
// master = stream source/sink side (testbench, upstream/downstream),
// slave  = the filter itself.
interface sobel_stream_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid, out_last
  );

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid, out_last
  );
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter over one IMG_W x IMG_H frame.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : frame start request, honoured only while idle
//   mode        : output select, latched on an accepted start
//                 0 |Gx|+|Gy|, 1 |Gx|, 2 |Gy|, 3 inverted threshold
//   busy        : high whenever a frame is in progress
//   frame_done  : one-cycle pulse after the last output has been taken
//   s           : input/output pixel streams (sobel_stream_if.slave)
// Every step pushes one pixel into the window (real input while running,
// zeros while flushing). The window centre lags the step count by one line
// plus one pixel, so IMG_W+1 flush steps drain the final outputs.
module sobel_stream_filter #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int THRESH = 150
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic         busy,
  output logic         frame_done,
  sobel_stream_if.slave s
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  // Signed gradient width; |Gx|+|Gy| <= 8*(2^PIX_W-1) also fits unsigned.
  localparam int GW = PIX_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [1:0]                      mode_q, mode_d;
  // win[r][c]: r=0 top row, c=0 left column
  logic [2:0][2:0][PIX_W-1:0]      win_q, win_d;
  logic [PIX_W-1:0]                out_pixel_q, out_pixel_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;

  // lb1 holds the previous line, lb2 the line before that
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb2_mem [IMG_W];

  logic                       out_free, step, flush_end, emit, is_last;
  logic [PIX_W-1:0]           pix_in, lb1_rd, lb2_rd, result;
  logic [2:0][2:0][PIX_W-1:0] win_n, tap;
  logic [CW-1:0]              cc;
  logic [RW-1:0]              cr;
  logic signed [GW-1:0]       gx, gy;
  logic [GW-1:0]              ax, ay, sum;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return signed'({3'b000, v});
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
    return (v[GW-1:PIX_W] != '0) ? '1 : v[PIX_W-1:0];
  endfunction

  assign lb1_rd     = lb1_mem[col_q];
  assign lb2_rd     = lb2_mem[col_q];
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign s.in_ready  = (state_q == S_RUN) && out_free;
  assign s.out_pixel = out_pixel_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    win_d       = win_q;
    out_pixel_d = out_pixel_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    out_free  = !out_valid_q || s.out_ready;
    // counters sit at (IMG_H+1, 1) once the final flush step has been taken
    flush_end = (row_q == RW'(IMG_H + 1)) && (col_q == CW'(1));
    step      = ((state_q == S_RUN) && s.in_valid && out_free) ||
                ((state_q == S_FLUSH) && !flush_end && out_free);
    pix_in    = (state_q == S_RUN) ? s.in_pixel : '0;

    // window contents after this step's shift
    for (int r = 0; r < 3; r++) begin
      win_n[r][0] = win_q[r][1];
      win_n[r][1] = win_q[r][2];
    end
    win_n[0][2] = lb2_rd;
    win_n[1][2] = lb1_rd;
    win_n[2][2] = pix_in;

    // centre coordinates of the shifted window; column 0 wraps to previous line
    if (col_q != '0) begin
      cc = col_q - CW'(1);
      cr = row_q - RW'(1);
    end else begin
      cc = CW'(IMG_W - 1);
      cr = row_q - RW'(2);
    end
    emit    = (row_q >= RW'(2)) || ((row_q == RW'(1)) && (col_q != '0));
    is_last = (cr == RW'(IMG_H - 1)) && (cc == CW'(IMG_W - 1));

    // taps off the image edge read as zero (also hides stale line buffers)
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap[r][c] = win_n[r][c];
        if ((r == 0 && cr == '0) || (r == 2 && cr == RW'(IMG_H - 1)) ||
            (c == 0 && cc == '0) || (c == 2 && cc == CW'(IMG_W - 1)))
          tap[r][c] = '0;
      end
    end

    gx = (ext(tap[0][2]) + (ext(tap[1][2]) <<< 1) + ext(tap[2][2])) -
         (ext(tap[0][0]) + (ext(tap[1][0]) <<< 1) + ext(tap[2][0]));
    gy = (ext(tap[0][0]) + (ext(tap[0][1]) <<< 1) + ext(tap[0][2])) -
         (ext(tap[2][0]) + (ext(tap[2][1]) <<< 1) + ext(tap[2][2]));
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    sum = ax + ay;

    unique case (mode_q)
      2'd0:    result = sat(sum);
      2'd1:    result = sat(ax);
      2'd2:    result = sat(ay);
      default: result = (sum >= GW'(THRESH)) ? '0 : '1;
    endcase

    if (out_valid_q && s.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (step) begin
      win_d = win_n;
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (emit) begin
        out_pixel_d = result;
        out_valid_d = 1'b1;
        out_last_d  = is_last;
      end
    end

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        col_d   = '0;
        row_d   = '0;
        mode_d  = mode;
      end
      S_RUN: if (step && col_q == CW'(IMG_W - 1) && row_q == RW'(IMG_H - 1))
        state_d = S_FLUSH;
      // leave only once the last pixel has actually been handed off
      S_FLUSH: if (out_valid_q && s.out_ready && out_last_q)
        state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      win_q       <= '0;
      out_pixel_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // line buffers: one read (combinational) and one write per step each
  always_ff @(posedge clk) begin
    if (step) begin
      lb1_mem[col_q] <= pix_in;
      lb2_mem[col_q] <= lb1_rd;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter: directed frames plus a
// randomized frame, all compared against a plain-arithmetic Sobel model.
module tb_sobel_stream_filter;
  localparam int PW = 8;
  localparam int W  = 128;
  localparam int H  = 128;
  localparam int N  = W * H;
  localparam int TH = 150;
  localparam int MAXV = 255;
  localparam int LIMIT = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       busy, frame_done;

  sobel_stream_if #(.PIX_W(PW)) bus ();

  sobel_stream_filter #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .frame_done(frame_done), .s(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int img [N];
  int expv[N];
  int got [N];

  // results of the most recent run_frame
  int g_nout, g_mism, g_first_bad, g_last_bad, g_done_cnt, g_done_cyc;
  int g_last_cyc, g_hold_bad, g_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return img[r*W + c];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clip(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic build_expect(input int md);
    int gx, gy;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1)) - (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1));
        case (md)
          0: expv[r*W+c] = clip(iabs(gx) + iabs(gy));
          1: expv[r*W+c] = clip(iabs(gx));
          2: expv[r*W+c] = clip(iabs(gy));
          default: expv[r*W+c] = (iabs(gx) + iabs(gy) >= TH) ? 0 : MAXV;
        endcase
      end
    end
  endtask

  // Runs one frame. vpct: in_valid probability (%). stall_at: output count at
  // which out_ready drops for 10 cycles (0 = never). abort_at: stop after this
  // many accepted inputs (0 = full frame). stray_at: input count at which a
  // start with mode 0 is pulsed mid-frame (0 = never).
  task automatic run_frame(input int md, input int vpct, input int stall_at,
                           input int abort_at, input int stray_at);
    int nin = 0, nout = 0, cyc = 0, stall_left = 0;
    bit stalled = 0, have_held = 0, fin = 0, stray_done = 0;
    int held = 0;
    g_mism = 0; g_first_bad = -1; g_last_bad = 0; g_done_cnt = 0;
    g_done_cyc = -1; g_last_cyc = -1; g_hold_bad = 0; g_timeout = 0;
    mode = 2'(md); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~2'(md);   // latched copy must be used from here on
    bus.out_ready = 1'b1;
    bus.in_pixel = PW'(img[0]);
    bus.in_valid = ($urandom_range(99) < vpct);
    while (!fin && cyc < LIMIT) begin
      @(negedge clk);
      if (frame_done) begin g_done_cnt++; g_done_cyc = cyc; end
      if (stall_left > 0) begin
        if (bus.out_valid) begin
          if (!have_held) begin held = int'(bus.out_pixel); have_held = 1; end
          else if (int'(bus.out_pixel) != held) g_hold_bad++;
        end
        if (bus.in_ready) g_hold_bad++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (nout < N) begin
          got[nout] = int'(bus.out_pixel);
          if (got[nout] != expv[nout]) begin
            g_mism++;
            if (g_first_bad < 0) g_first_bad = nout;
          end
          if (bus.out_last !== (nout == N-1)) g_last_bad++;
        end else g_mism++;
        nout++;
        if (nout == N) g_last_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) nin++;
      @(posedge clk); #1;
      cyc++;
      if (abort_at > 0 && nin >= abort_at) fin = 1;
      if (g_last_cyc >= 0 && cyc > g_last_cyc + 3) fin = 1;
      bus.in_valid = (nin < N) && ($urandom_range(99) < vpct);
      bus.in_pixel = (nin < N) ? PW'(img[nin]) : '0;
      if (stall_at > 0 && !stalled && nout >= stall_at) begin
        stall_left = 10; stalled = 1;
      end else if (stall_left > 0) stall_left--;
      bus.out_ready = (stall_left == 0);
      if (stray_at > 0 && !stray_done && nin >= stray_at) begin
        start = 1'b1; mode = 2'd0; stray_done = 1;
      end else start = 1'b0;
    end
    if (!fin) g_timeout = 1;
    g_nout = nout;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic frame_checks(input string t);
    chk({t, "_timeout"}, g_timeout, 0);
    chk({t, "_count"}, g_nout, N);
    chk({t, "_data_mismatches"}, g_mism, 0);
    if (g_mism != 0) $display("  %s first bad index %0d", t, g_first_bad);
    chk({t, "_last_flag_errors"}, g_last_bad, 0);
    chk({t, "_done_pulses"}, g_done_cnt, 1);
    chk({t, "_done_cycle"}, g_done_cyc, g_last_cyc + 1);
    chk({t, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int quiet;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    bus.in_valid = 1'b0; bus.in_pixel = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_pixel", bus.out_pixel, 0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // frame abandoned by reset after 5000 inputs
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_expect(0);
    run_frame(0, 100, 0, 5000, 0);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1; #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_out_last", bus.out_last, 1'b0);
    chk("abort_out_pixel", bus.out_pixel, 0);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b1;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || busy || bus.in_ready) quiet++;
    end
    chk("abort_quiet_after", quiet, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // mode 0, flat image, with a 10-cycle output stall mid-frame
    foreach (img[i]) img[i] = 100;
    build_expect(0);
    run_frame(0, 100, N/2, 0, 0);
    frame_checks("m0_flat");
    chk("m0_stall_hold", g_hold_bad, 0);
    chk("m0_corner00", got[0], 255);
    chk("m0_interior", got[64*W+64], 0);
    chk("m0_corner_last", got[N-1], 255);

    // mode 3, flat image
    build_expect(3);
    run_frame(3, 100, 0, 0, 0);
    frame_checks("m3_flat");
    chk("m3_interior", got[64*W+64], 255);
    chk("m3_top_edge", got[5], 0);
    chk("m3_left_edge", got[64*W], 0);
    chk("m3_corner_last", got[N-1], 0);

    // mode 1, vertical step edge at column 64
    foreach (img[i]) img[i] = ((i % W) >= 64) ? 20 : 0;
    build_expect(1);
    run_frame(1, 100, 0, 0, 0);
    frame_checks("m1_step");
    chk("m1_col63", got[5*W+63], 80);
    chk("m1_col64", got[126*W+64], 80);
    chk("m1_flat_interior", got[5*W+10], 0);

    // mode 2, random image, random input gaps, stray start mid-frame
    foreach (img[i]) img[i] = int'($urandom_range(255));
    build_expect(2);
    run_frame(2, 70, 0, 0, 3000);
    frame_checks("m2_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
